regfile_uart_tx: RTL
====================

// Module: regfile_uart_tx
// PURPOSE
//  UART 8N1 transmitter that dumps a snapshot of the CPU register file to the host.
//  Sits beside the UART receive / register-file block on the processor side, where it acts as the tx end of the host link.
//  Takes the flat regfile bus (x0..x31) and serialises it byte by byte.
//  Reply format: register 0 first; within each register, least-significant byte first.
// PARAMETERS
//  CLKS_PER_BIT  104  clk cycles per UART bit (12 MHz / 115200); must be >= 2
//  NUM_REGS      32   number of registers in the dump
//  REG_WIDTH     32   bits per register; must be a multiple of 8
// PORTS
//  clk      in   1                     system clock; single clock domain
//  rst_n    in   1                     asynchronous, active-low reset
//  start    in   1                     request a dump; sampled on rising clk
//  regfile  in   NUM_REGS*REG_WIDTH    flat register file; reg i at [i*REG_WIDTH +: REG_WIDTH]
//  busy     out  1                     high while a dump is in progress
//  done     out  1                     one-cycle pulse when the dump completes
//  tx       out  1                     UART serial line; idles high
// BEHAVIOUR
//  Reset (rst_n=0, async): tx=1, busy=0, done=0, FSM=IDLE, all counters cleared.
//    Applies immediately, including mid-frame; the partial byte is abandoned.
//  FSM states:
//    IDLE  -> START  on start=1: regfile latched into snapshot buffer; byte_idx=0; busy=1.
//    START -> DATA   tx=0 for CLKS_PER_BIT cycles.
//    DATA  -> STOP   8 bits, LSB first, CLKS_PER_BIT cycles each; bit_idx counts 0..7.
//    STOP  -> START  tx=1 for CLKS_PER_BIT cycles, then next byte if byte_idx < NBYTES-1.
//    STOP  -> IDLE   after the last byte: busy->0 and done=1 on the same edge, for one cycle.
//  Byte framing: no idle gap between bytes; a start bit directly follows the previous stop bit.
//  NBYTES = NUM_REGS*REG_WIDTH/8 (128 at defaults).
//  Latency: start sampled at edge k -> tx low from edge k+1 (tx is registered).
//  Dump length: NBYTES*10*CLKS_PER_BIT cycles from edge k+1 to the done edge.
//  Snapshot rule: regfile is sampled only on the accepted start edge.
//    Changes to regfile during a dump do not affect the transmitted data.
//  start while busy=1: ignored, with no effect on the dump in progress.
//  start during the done cycle: accepted (FSM is IDLE); the new dump begins next edge.
//  Counters:
//    baud counter runs 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
//    byte_idx width $clog2(NBYTES+1); no wrap, the FSM exits at NBYTES-1.
//  tx is glitch-free: driven straight from a flop, never from combinational decode.
// CONFIGURATION
//  REGFILE_TX_HEADER_EN defined:
//    A sync byte 0xA5 is sent before register data; the frame is then NBYTES+1 bytes.
//    busy and done timing extend by 10*CLKS_PER_BIT cycles.
//  REGFILE_TX_HEADER_EN undefined: no header; the first byte on the line is reg0[7:0].
// TESTING  (bench: CLKS_PER_BIT=4, NUM_REGS=2 unless stated)
//  1. rst_n=0 -> tx=1, busy=0, done=0 immediately (async); they hold after release with start=0.
//  2. reg0=0x11223344, reg1=0xDEADBEEF, 1-cycle start:
//     -> line decodes 44 33 22 11 EF BE AD DE;
//     -> each frame 40 cycles; done pulse exactly 320 cycles after the first tx fall.
//  3. Change regfile to all-ones one cycle after start -> transmitted bytes still equal scenario 2.
//  4. start re-pulsed while busy -> no restart and no extra bytes;
//     start held high through the done cycle -> second dump begins on the next edge.
//  5. rst_n low mid-DATA of byte 3 -> tx=1 and busy=0 at once;
//     next start sends the full dump from byte 0.
//  6. With REGFILE_TX_HEADER_EN: first byte decodes 0xA5, then scenario-2 bytes; done after 360 cycles.

Source files
------------

// File: rtl/regfile_uart_tx.sv
// UART 8N1 dump of a register-file snapshot: reg0 first, LSB byte first. REGFILE_TX_HEADER_EN prepends sync byte 0xA5.
// Latency: tx falls one edge after start is accepted; a dump lasts NFRAMES*10*CLKS_PER_BIT cycles.
// Backpressure: none on the line; start is ignored while busy and accepted again in the done cycle.
module regfile_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int NUM_REGS     = 32,
  parameter int REG_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_REGS*REG_WIDTH-1:0] regfile,
  output logic                          busy,
  output logic                          done,
  output logic                          tx
);

  localparam int NBYTES = NUM_REGS * REG_WIDTH / 8;
`ifdef REGFILE_TX_HEADER_EN
  localparam int NFRAMES = NBYTES + 1;
`else
  localparam int NFRAMES = NBYTES;
`endif
  localparam int SNAP_W = NFRAMES * 8;
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int BW     = $clog2(NFRAMES + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     baud_cnt;
  logic [2:0]        bit_idx;
  logic [BW-1:0]     byte_idx;
  logic [SNAP_W-1:0] snap;
  logic              baud_last;
  logic              byte_last;

  assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign byte_last = (byte_idx == BW'(NFRAMES - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = START;
      START:   if (baud_last) state_nxt = DATA;
      DATA:    if (baud_last && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (baud_last) state_nxt = byte_last ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot shifts right one bit per data bit, so the next byte lands at [7:0] by itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      snap     <= '0;
    end else begin
      done     <= 1'b0;
      baud_cnt <= (state == IDLE || baud_last) ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          tx       <= 1'b0;
          byte_idx <= '0;
`ifdef REGFILE_TX_HEADER_EN
          snap     <= {regfile, 8'hA5};
`else
          snap     <= regfile;
`endif
        end
        START: if (baud_last) begin
          tx      <= snap[0];
          snap    <= snap >> 1;
          bit_idx <= '0;
        end
        DATA: if (baud_last) begin
          if (bit_idx == 3'd7) begin
            tx <= 1'b1;
          end else begin
            tx      <= snap[0];
            snap    <= snap >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: if (baud_last) begin
          if (byte_last) begin
            done <= 1'b1;
          end else begin
            tx       <= 1'b0;
            byte_idx <= byte_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
